seq_divider: RTL and testbench

Sequential signed integer divider: the inverse operation of the team's combinational Booth multiplier. It accepts a two's-complement dividend and divisor, runs one restoring-division step per clock on operand magnitudes, applies sign correction, and presents quotient and remainder with a one-cycle `done` pulse. It sits beside the multiplier in the lab-08 arithmetic unit and shares its `NR_BITS` parameterisation, so a product can be divided back by one of its factors.

---
 rtl/seq_divider.sv | 148 ++++++++++++++
 tb/tb_seq_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, then sign correction; truncates toward zero, remainder follows dividend.
module seq_divider #(
  parameter int unsigned NR_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NR_BITS-1:0] N,
  input  logic [NR_BITS-1:0] D,
  output logic [NR_BITS-1:0] Q,
  output logic [NR_BITS-1:0] Rem,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int unsigned CW = $clog2(NR_BITS + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(NR_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               sign_n_q, sign_n_d;
  logic               sign_d_q, sign_d_d;
  logic [NR_BITS-1:0] dmag_q, dmag_d;
  logic [NR_BITS:0]   prem_q, prem_d;
  logic [NR_BITS-1:0] qreg_q, qreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NR_BITS-1:0] quo_q, quo_d;
  logic [NR_BITS-1:0] rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [NR_BITS:0] shifted;
  logic [NR_BITS:0] trial;

  // Remainder never exceeds |D| <= 2^(NR_BITS-1), so NR_BITS+1 bits hold the shift.
  assign shifted = {prem_q[NR_BITS-1:0], qreg_q[NR_BITS-1]};
  assign trial   = shifted - {1'b0, dmag_q};

  always_comb begin
    state_d  = state_q;
    sign_n_d = sign_n_q;
    sign_d_d = sign_d_q;
    dmag_d   = dmag_q;
    prem_d   = prem_q;
    qreg_d   = qreg_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (D == '0) begin
            quo_d   = '1;
            rem_d   = N;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            sign_n_d = N[NR_BITS-1];
            sign_d_d = D[NR_BITS-1];
            dmag_d   = D[NR_BITS-1] ? -D : D;
            qreg_d   = N[NR_BITS-1] ? -N : N;
            prem_d   = '0;
            cnt_d    = CNT_INIT;
            dbz_d    = 1'b0;
            busy_d   = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[NR_BITS]) begin
          prem_d = trial;
          qreg_d = {qreg_q[NR_BITS-2:0], 1'b1};
        end else begin
          prem_d = shifted;
          qreg_d = {qreg_q[NR_BITS-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quo_d   = (sign_n_q ^ sign_d_q) ? -qreg_q : qreg_q;
        rem_d   = sign_n_q ? -prem_q[NR_BITS-1:0] : prem_q[NR_BITS-1:0];
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_n_q <= 1'b0;
      sign_d_q <= 1'b0;
      dmag_q   <= '0;
      prem_q   <= '0;
      qreg_q   <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_n_q <= sign_n_d;
      sign_d_q <= sign_d_d;
      dmag_q   <= dmag_d;
      prem_q   <= prem_d;
      qreg_q   <= qreg_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Q           = quo_q;
  assign Rem         = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic/timing model checked every cycle, plus
// directed operations with hand-computed literal results.
module tb_seq_divider;

  localparam int unsigned NR_BITS = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [NR_BITS-1:0] N;
  logic [NR_BITS-1:0] D;
  logic [NR_BITS-1:0] Q;
  logic [NR_BITS-1:0] Rem;
  logic               busy;
  logic               done;
  logic               div_by_zero;

  int checks = 0;
  int failures = 0;

  seq_divider #(.NR_BITS(NR_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .N          (N),
    .D          (D),
    .Q          (Q),
    .Rem        (Rem),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k counts edges since acceptance (0 = accepting edge); results
  // come from integer division, which truncates toward zero.
  bit                 m_active = 0;
  int                 m_k = 0;
  int                 m_done_k = 0;
  logic [NR_BITS-1:0] m_q = '0, m_rem = '0, m_res_q = '0, m_res_r = '0;
  logic               m_dbz = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0;
      m_k      = 0;
      m_q      = '0;
      m_rem    = '0;
      m_dbz    = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k == m_done_k) begin
        m_q   = m_res_q;
        m_rem = m_res_r;
      end
      if (m_k == m_done_k + 1) m_active = 0;
    end else if (start) begin
      int nn, dd, qq, rr;
      nn = int'($signed(N));
      dd = int'($signed(D));
      m_active = 1;
      m_k      = 0;
      if (dd == 0) begin
        m_q      = '1;
        m_rem    = N;
        m_dbz    = 1;
        m_done_k = 0;
      end else begin
        qq       = nn / dd;
        rr       = nn % dd;
        m_res_q  = qq[NR_BITS-1:0];
        m_res_r  = rr[NR_BITS-1:0];
        m_dbz    = 0;
        m_done_k = NR_BITS + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_busy", busy, (m_active && m_done_k != 0 && m_k <= NR_BITS) ? 1 : 0);
      check("cyc_done", done, (m_active && m_k == m_done_k) ? 1 : 0);
      check("cyc_q", Q, m_q);
      check("cyc_rem", Rem, m_rem);
      check("cyc_dbz", div_by_zero, m_dbz);
    end
  end

  task automatic run_op(input logic [NR_BITS-1:0] n, input logic [NR_BITS-1:0] d,
                        input logic [NR_BITS-1:0] eq, input logic [NR_BITS-1:0] er,
                        input logic edbz, input int elat, input string name);
    int lat;
    @(negedge clk);
    start = 1'b1;
    N     = n;
    D     = d;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_lat"}, lat, elat);
    check({name, "_q"}, Q, eq);
    check({name, "_rem"}, Rem, er);
    check({name, "_dbz"}, div_by_zero, edbz);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    start = 1'b0;
    N     = '0;
    D     = '0;
    #1;
    check("rst_q", Q, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);

    run_op(4'd7, 4'd2, 4'b0011, 4'b0001, 1'b0, 6, "p7_p2");
    run_op(4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 6, "m7_p2");
    run_op(4'd7, 4'b1110, 4'b1101, 4'b0001, 1'b0, 6, "p7_m2");
    run_op(4'b1001, 4'b1110, 4'b0011, 4'b1111, 1'b0, 6, "m7_m2");
    run_op(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 6, "m8_m1");
    run_op(4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 6, "m8_p1");
    run_op(4'd5, 4'd0, 4'b1111, 4'b0101, 1'b1, 1, "dbz5");
    run_op(4'd6, 4'd3, 4'b0010, 4'b0000, 1'b0, 6, "p6_p3");

    // start held high with operands changing during the operation
    @(negedge clk);
    start = 1'b1;
    N     = 4'd7;
    D     = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i < 6) begin
        N = 4'(i);
        D = 4'(i + 9);
      end
    end
    check("hold_done", done, 1);
    check("hold_q", Q, 4'b0011);
    check("hold_rem", Rem, 4'b0001);
    N = 4'd6;
    D = 4'd3;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold2_lat", lat, 6);
    check("hold2_q", Q, 4'b0010);
    @(negedge clk);

    // asynchronous reset after step 2
    @(negedge clk);
    start = 1'b1;
    N     = 4'd7;
    D     = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_q", Q, 0);
    check("arst_rem", Rem, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    run_op(4'd7, 4'd2, 4'b0011, 4'b0001, 1'b0, 6, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
